// File: rtl/gpio_irq_dispatch_if.sv
// Bus bundle for the GPIO interrupt dispatcher: APB4 read master plus the
// valid/ready event port toward the consumer.
interface gpio_irq_dispatch_if #(
  parameter int IDX_W = 5
) ();
  logic [31:0]      paddr_o;
  logic             psel_o;
  logic             penable_o;
  logic             pwrite_o;
  logic [31:0]      pwdata_o;
  logic [3:0]       pstrb_o;
  logic [2:0]       pprot_o;
  logic [31:0]      prdata_i;
  logic             pready_i;
  logic             pslverr_i;
  logic             evt_valid_o;
  logic [IDX_W-1:0] evt_idx_o;
  logic             evt_ready_i;

  modport master (
    output paddr_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o, pprot_o,
    output evt_valid_o, evt_idx_o,
    input  prdata_i, pready_i, pslverr_i, evt_ready_i
  );

  modport slave (
    input  paddr_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o, pprot_o,
    input  evt_valid_o, evt_idx_o,
    output prdata_i, pready_i, pslverr_i, evt_ready_i
  );
endinterface

// File: rtl/gpio_irq_dispatch.sv
// Services a GPIO interrupt: APB read of INTSTATUS, then hands the pending pins
// out one at a time in round-robin order over a valid/ready event port.
//
// state    | meaning
// IDLE     | waiting for enable_i && irq_i
// SETUP    | APB setup phase (psel=1, penable=0)
// ACCESS   | APB access phase, held until pready
// DISPATCH | presenting pending pins to the consumer
module gpio_irq_dispatch #(
  parameter int          GPIO_NUM  = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          IDX_W     = (GPIO_NUM > 1) ? $clog2(GPIO_NUM) : 1
) (
  input  logic                hclk,
  input  logic                hreset,
  input  logic                enable_i,
  input  logic                irq_i,
  gpio_irq_dispatch_if.master bus,
  output logic                busy_o,
  output logic                err_o,
  output logic [15:0]         served_cnt_o
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DISPATCH} state_t;

  state_t                state, state_nxt;
  logic [GPIO_NUM-1:0]   pending, pending_nxt, one_hot, rotated;
  logic [2*GPIO_NUM-1:0] rot_full;
  logic [IDX_W-1:0]      rr_ptr, sel_idx;
  logic                  found, accept, rd_done, rd_ok, err_q;
  logic [15:0]           served_cnt;
  int                    sum;

  assign rd_done = (state == ACCESS) && bus.pready_i;
  assign rd_ok   = rd_done && !bus.pslverr_i;
  assign accept  = (state == DISPATCH) && bus.evt_ready_i;

  // Rotate pending so bit 0 is rr_ptr, then take the lowest set bit.
  always_comb begin
    rot_full = {pending, pending} >> rr_ptr;
    rotated  = rot_full[GPIO_NUM-1:0];
    found    = 1'b0;
    sum      = 0;
    sel_idx  = '0;
    for (int i = 0; i < GPIO_NUM; i++) begin
      if (!found && rotated[i]) begin
        found = 1'b1;
        sum   = int'(rr_ptr) + i;
        if (sum >= GPIO_NUM) sum = sum - GPIO_NUM;
        sel_idx = IDX_W'(sum);
      end
    end
    one_hot     = GPIO_NUM'(1) << sel_idx;
    pending_nxt = pending & ~one_hot;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (enable_i && irq_i) state_nxt = SETUP;
      SETUP:    state_nxt = ACCESS;
      ACCESS: begin
        if (bus.pready_i) begin
          if (bus.pslverr_i || (bus.prdata_i[GPIO_NUM-1:0] == '0)) state_nxt = IDLE;
          else state_nxt = DISPATCH;
        end
      end
      DISPATCH: if (accept && (pending_nxt == '0)) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state      <= IDLE;
      pending    <= '0;
      rr_ptr     <= '0;
      served_cnt <= '0;
      err_q      <= 1'b0;
    end else begin
      state <= state_nxt;
      err_q <= rd_done && bus.pslverr_i;
      if (rd_ok) begin
        pending <= bus.prdata_i[GPIO_NUM-1:0];
      end else if (accept) begin
        pending <= pending_nxt;
        rr_ptr  <= (sel_idx == IDX_W'(GPIO_NUM - 1)) ? '0 : sel_idx + IDX_W'(1);
        if (served_cnt != 16'hFFFF) served_cnt <= served_cnt + 16'd1;
      end
    end
  end

  // All outputs decode registered state only; no path from prdata or evt_ready.
  assign bus.paddr_o     = BASE_ADDR + 32'h18;
  assign bus.psel_o      = (state == SETUP) || (state == ACCESS);
  assign bus.penable_o   = (state == ACCESS);
  assign bus.pwrite_o    = 1'b0;
  assign bus.pwdata_o    = 32'h0;
  assign bus.pstrb_o     = 4'h0;
  assign bus.pprot_o     = 3'h0;
  assign bus.evt_valid_o = (state == DISPATCH);
  assign bus.evt_idx_o   = sel_idx;
  assign busy_o          = (state != IDLE);
  assign err_o           = err_q;
  assign served_cnt_o    = served_cnt;

endmodule

// File: doc/gpio_irq_dispatch.md
# gpio_irq_dispatch

Interrupt service sequencer for the APB4 GPIO block. On GPIO `irq`, it acts as an APB4 master, reads the GPIO INTSTATUS register (offset 0x18), which also clears the GPIO interrupt, and latches the status word. It then hands the pending pins one at a time, in round-robin order, to a downstream consumer over a valid/ready event port. It sits between the GPIO slave's register port (via the APB fabric) and the system event/CPU-offload logic.

## Interface
- GPIO_NUM, 32: number of pins reported; 1..32; status bits above GPIO_NUM-1 are ignored.
- BASE_ADDR, 32'h0000_0000: APB base address of the GPIO instance.
- IDX_W, $clog2(GPIO_NUM) (min 1): width of event index.

Ports:
- hclk  in  1  clock.
- hreset  in  1  asynchronous, active-high reset.
- enable_i  in  1  allows new service sequences to start.
- irq_i  in  1  GPIO interrupt, level, synchronous to hclk.
- paddr_o  out  32  constant BASE_ADDR+32'h18.
- psel_o  out  1  APB select.
- penable_o  out  1  APB enable.
- pwrite_o  out  1  tied 0 (reads only).
- pwdata_o  out  32  tied 0.
- pstrb_o  out  4  tied 0.
- pprot_o  out  3  tied 0.
- prdata_i  in  32  APB read data.
- pready_i  in  1  APB ready.
- pslverr_i  in  1  APB slave error.
- evt_valid_o  out  1  event available.
- evt_idx_o  out  IDX_W  pin index of the event.
- evt_ready_i  in  1  consumer accepts the event.
- busy_o  out  1  FSM not in IDLE.
- err_o  out  1  one-cycle pulse when an APB read returns pslverr.
- served_cnt_o  out  16  saturating count of accepted events.

## Operation
- FSM states: IDLE, SETUP, ACCESS, DISPATCH.
- **IDLE**
  - If `enable_i && irq_i`, go to SETUP.
- **SETUP**
  - `psel_o`=1, `penable_o`=0.
  - Always go to ACCESS next cycle.
- **ACCESS**
  - `psel_o`=1, `penable_o`=1.
  - Hold while `pready_i`=0.
  - When `pready_i`=1 and `pslverr_i`=1: `err_o` pulses, data is discarded, go to IDLE.
  - When `pready_i`=1 and `pslverr_i`=0: `pending <= prdata_i[GPIO_NUM-1:0]`.
    - If that value is 0, go to IDLE.
    - Otherwise go to DISPATCH.
- **DISPATCH**
  - `evt_valid_o`=1.
  - `evt_idx_o` = first set bit of `pending`, searching upward from `rr_ptr` with wrap-around.
  - On `evt_valid_o && evt_ready_i`:
    - Clear `pending[evt_idx_o]`.
    - `rr_ptr <= (evt_idx_o+1) mod GPIO_NUM`.
    - `served_cnt_o` increments, saturating at 16'hFFFF.
  - When the last bit clears, go to IDLE in the same transition.
- **Handshake rules**
  - `evt_idx_o` is stable while `evt_valid_o`=1 and `evt_ready_i`=0.
  - `evt_valid_o` never drops without acceptance, except on reset.
- `rr_ptr` persists across sequences; it is reset to 0.
- `irq_i` is ignored outside IDLE. A new GPIO interrupt raised during DISPATCH is serviced on return to IDLE.
- **`enable_i` deasserted mid-sequence**
  - An in-flight APB transfer is never aborted.
  - DISPATCH runs to completion.
  - Only new starts are blocked.
- `busy_o` = (state != IDLE).
- **Reset (async, any state)**
  - State goes to IDLE.
  - `pending`, `rr_ptr` and `served_cnt_o` are cleared to 0.
  - All outputs take their reset values (see Timing).

## Timing
- **Reset values**
  - `psel_o`, `penable_o`, `evt_valid_o`, `busy_o`, `err_o` = 0.
  - `evt_idx_o` = 0.
  - `served_cnt_o` = 0.
  - Tied outputs at their constants.
- **Latency, zero-wait slave**
  - `irq_i` sampled high at edge 0.
  - SETUP in cycle 1.
  - ACCESS in cycle 2.
  - `evt_valid_o` high in cycle 3.
  - Each wait state adds 1 cycle.
- Throughput: with `evt_ready_i` held at 1, one event per cycle. N pending bits drain in N cycles, then IDLE.
- **Return to IDLE**
  - The earliest new SETUP is the cycle after IDLE is entered.
  - The GPIO clears its `irq` on the ACCESS edge, so a stale `irq_i` does not cause a re-read.
- All outputs are registered or decoded from registered state; there is no combinational path from `prdata_i` or `evt_ready_i` to any output.

## Test plan
- Single pin: GPIO_NUM=32, `irq_i`=1, `prdata_i`=32'h0000_0010, `pready_i`=1 → `psel_o` cycle 1; `penable_o` cycle 2; `paddr_o`=BASE+0x18; `evt_valid_o` cycle 3 with idx 4; after ready, IDLE; `served_cnt_o`=1.
- Round-robin: status 32'h8000_0005 with `evt_ready_i`=1 and `rr_ptr`=0 → idx 0, 2, 31 on consecutive cycles. A second sequence with status 32'h0000_0005 and `rr_ptr`=0 (wrapped after 31) → idx 0, 2.
- Backpressure: `evt_ready_i`=0 for 5 cycles with status 32'h0000_0300 → idx 8 held stable 5 cycles; then 8 and 9 are accepted.
- Wait states and error: `pready_i`=0 for 3 cycles, then 1 with `pslverr_i`=1 → `penable_o` high 4 cycles; `err_o` pulses once; no event; IDLE.
- Zero status and disable: status 0 → IDLE after ACCESS with no event. `enable_i`=0 with `irq_i`=1 → `psel_o` stays 0.
- Reset mid-DISPATCH with 3 bits pending → next cycle `evt_valid_o`=0, `busy_o`=0, `served_cnt_o`=0, `rr_ptr`=0.
